// File: rtl/apb_request_arbiter.sv
// rtl/apb_request_arbiter.sv - round-robin arbiter driving one APB master port from NUM_REQ requesters
module apb_request_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  input  logic [31:0]             PRDATA,
  input  logic                    pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Every transfer walks all four states; DONE doubles as the mandatory
  // idle bus cycle so PSEL can never stay high across two transfers.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [IDX_W-1:0] rr_ptr;      // last requester served
  logic [IDX_W-1:0] owner;       // requester owning the current transfer
  logic [IDX_W-1:0] winner;      // arbitration result for this cycle
  logic [IDX_W-1:0] cand;
  logic             any_req;
  int               scan_idx;

  logic             sel_write;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;

  logic             accept;

  // Round-robin pick: first set req bit scanning upward from rr_ptr+1 with wrap
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      cand     = IDX_W'(scan_idx);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Steer the winning requester's command fields toward the bus registers
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == IDX_W'(j)) begin
        sel_write = req_write[j];
        sel_addr  = req_addr[j*32 +: 32];
        sel_wdata = req_wdata[j*32 +: 32];
      end
    end
  end

  // A command is accepted only in IDLE, out of reset, with someone asking
  assign accept = (state == ST_IDLE) && any_req && n_rst;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state outputs; grant and rsp_valid are single-cycle pulses
  always_comb begin
    state_next = state;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    grant      = '0;
    rsp_valid  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          grant[winner] = 1'b1;
          state_next    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL       = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL       = 1'b1;
        PENABLE    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid[owner] = 1'b1;
        state_next       = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command latch: bus address/data/direction hold from grant until the next grant
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      owner  <= '0;
    end else if (accept) begin
      PADDR  <= sel_addr;
      PWDATA <= sel_wdata;
      PWRITE <= sel_write;
      owner  <= winner;
    end
  end

  // Capture slave response at the end of ACCESS; a clean write returns zero data,
  // while an erroring write passes the slave's error word through
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rsp_rdata <= (PWRITE && !pslverr) ? 32'h0 : PRDATA;
      rsp_err   <= pslverr;
    end
  end

  // Round-robin pointer advances to the owner once its transfer completes;
  // reset value NUM_REQ-1 gives requester 0 first priority
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (state == ST_DONE) begin
      rr_ptr <= owner;
    end
  end

endmodule

// File: tb/tb_apb_request_arbiter.sv
// tb/tb_apb_request_arbiter.sv - self-checking bench for apb_request_arbiter
module tb_apb_request_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [31:0]     PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE;
  logic            PSEL;
  logic            PENABLE;
  logic [31:0]     PRDATA;
  logic            pslverr;

  always #5 clk = ~clk;

  apb_request_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .pslverr   (pslverr)
  );

  // Slave: addresses with bit 8 set are unmapped and return an error word
  assign pslverr = PADDR[8];
  assign PRDATA  = PADDR[8] ? 32'hBAD1_BAD1 : {~PADDR[15:0], PADDR[15:0]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[r]               = 1'b1;
    req_write[r]         = w;
    req_addr[r*32 +: 32] = a;
    req_wdata[r*32 +: 32] = d;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  typedef struct {
    int          r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  exp_onehot;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // Reference model state
  int          m_age;
  int          m_rr;
  int          m_owner;
  logic        m_w;
  logic [31:0] m_a;
  logic [31:0] m_d;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [N-1:0] m_last_grant;

  initial begin
    n_rst = 1'b0;
    clear_inputs();

    vecs[0] = '{0, 1'b0, 32'h0000_0004, 32'h0,         4'b0001, 32'hFFFB_0004, 1'b0};
    vecs[1] = '{2, 1'b1, 32'h0000_0000, 32'h0000_00FF, 4'b0100, 32'h0,         1'b0};
    vecs[2] = '{1, 1'b0, 32'h0000_0100, 32'h0,         4'b0010, 32'hBAD1_BAD1, 1'b1};
    vecs[3] = '{3, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1000, 32'hBAD1_BAD1, 1'b1};
    vecs[4] = '{3, 1'b0, 32'h0000_0020, 32'h0,         4'b1000, 32'hFFDF_0020, 1'b0};
    vecs[5] = '{1, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'b0010, 32'h0,         1'b0};

    // Reset, then quiet bus for 10 cycles
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #3;
      check("reset_ctrl", {grant, rsp_valid, rsp_err, PWRITE, PSEL, PENABLE}, 64'h0);
      check("reset_data", {rsp_rdata, PADDR}, 64'h0);
      check("reset_wdata", PWDATA, 64'h0);
      tick();
    end

    // Table-driven single-requester transfers
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      set_req(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
      #3;
      check("vec_grant", grant, vecs[i].exp_onehot);
      check("vec_idle_psel", {PSEL, PENABLE}, 2'b00);
      tick();
      clear_inputs();
      #3;
      check("vec_setup_bus", {PSEL, PENABLE, PWRITE}, {2'b10, vecs[i].w});
      check("vec_setup_addr", PADDR, vecs[i].a);
      check("vec_setup_wdata", PWDATA, vecs[i].d);
      tick();
      #3;
      check("vec_access_bus", {PSEL, PENABLE, PWRITE}, {2'b11, vecs[i].w});
      check("vec_access_addr", PADDR, vecs[i].a);
      check("vec_access_wdata", PWDATA, vecs[i].d);
      check("vec_access_grant", grant, 4'b0000);
      tick();
      #3;
      check("vec_done_valid", rsp_valid, vecs[i].exp_onehot);
      check("vec_done_rdata", rsp_rdata, vecs[i].exp_rdata);
      check("vec_done_err", rsp_err, vecs[i].exp_err);
      check("vec_done_psel", {PSEL, PENABLE}, 2'b00);
      tick();
      #3;
      check("vec_after_valid", rsp_valid, 4'b0000);
    end

    // All requesters held from reset: grants 0,1,2,3,0 spaced 4 cycles apart
    clear_inputs();
    req = 4'b1111;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      logic [3:0] exp_g;
      exp_g = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
      #3;
      check("rr_grant", grant, exp_g);
      tick();
    end

    // Reset during ACCESS abandons the transfer and restores priority to requester 0
    clear_inputs();
    do_reset();
    set_req(0, 1'b0, 32'h0000_0008, 32'h0);
    #3;
    check("rst_first_grant", grant, 4'b0001);
    tick();
    clear_inputs();
    tick();
    tick();
    tick();
    set_req(1, 1'b0, 32'h0000_0010, 32'h0);
    #3;
    check("rst_second_grant", grant, 4'b0010);
    tick();
    clear_inputs();
    tick();
    #3;
    check("rst_in_access", {PSEL, PENABLE}, 2'b11);
    n_rst = 1'b0;
    tick();
    #3;
    check("rst_psel_low", {PSEL, PENABLE}, 2'b00);
    check("rst_no_valid", rsp_valid, 4'b0000);
    tick();
    n_rst = 1'b1;
    #3;
    check("rst_no_valid_late", rsp_valid, 4'b0000);
    req = 4'b1111;
    #1;
    check("rst_restart_grant", grant, 4'b0001);
    tick();
    clear_inputs();
    tick();
    tick();
    tick();

    // Requester 1 raises then drops its request while another transfer is busy
    clear_inputs();
    do_reset();
    set_req(0, 1'b1, 32'h0000_000C, 32'h5555_0000);
    #3;
    check("wd_grant0", grant, 4'b0001);
    tick();
    clear_inputs();
    set_req(1, 1'b0, 32'h0000_0030, 32'h0);
    #3;
    check("wd_setup_grant", grant, 4'b0000);
    tick();
    clear_inputs();
    #3;
    check("wd_access_grant", grant, 4'b0000);
    tick();
    #3;
    check("wd_done_grant", grant, 4'b0000);
    check("wd_done_valid", rsp_valid, 4'b0001);
    tick();
    #3;
    check("wd_idle_grant", grant, 4'b0000);
    tick();
    #3;
    check("wd_idle_grant2", grant, 4'b0000);

    // Randomized traffic against a transaction-level reference model
    clear_inputs();
    do_reset();
    m_age        = -1;
    m_rr         = N - 1;
    m_owner      = 0;
    m_w          = 1'b0;
    m_a          = '0;
    m_d          = '0;
    m_rdata      = '0;
    m_err        = 1'b0;
    m_last_grant = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int         win;
      logic [3:0] exp_g;
      for (int r = 0; r < N; r++) begin
        if (m_last_grant[r] || !req[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end else begin
            req[r] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[r] = 1'b0;
        end
      end
      n_rst = ($urandom_range(0, 299) != 0);
      #3;
      win = -1;
      if (m_age < 0 && n_rst) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
        end
      end
      exp_g = (win >= 0) ? 4'(1 << win) : 4'b0000;
      check("rnd_grant", grant, exp_g);
      check("rnd_bus", {PSEL, PENABLE}, {(m_age == 1 || m_age == 2), (m_age == 2)});
      check("rnd_valid", rsp_valid, (m_age == 3) ? 4'(1 << m_owner) : 4'b0000);
      if (m_age == 1 || m_age == 2) begin
        check("rnd_cmd", {PWRITE, PADDR}, {m_w, m_a});
        check("rnd_wdata", PWDATA, m_d);
      end
      if (m_age == 3) begin
        check("rnd_rsp", {rsp_err, rsp_rdata}, {m_err, m_rdata});
      end
      if (!n_rst) begin
        m_age = -1;
        m_rr  = N - 1;
      end else if (m_age < 0) begin
        if (win >= 0) begin
          m_owner = win;
          m_w     = req_write[win];
          m_a     = req_addr[win*32 +: 32];
          m_d     = req_wdata[win*32 +: 32];
          m_age   = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        m_err   = m_a[8];
        m_rdata = (m_w && !m_err) ? 32'h0 :
                  (m_err ? 32'hBAD1_BAD1 : {~m_a[15:0], m_a[15:0]});
        m_age   = 3;
      end else begin
        m_rr  = m_owner;
        m_age = -1;
      end
      m_last_grant = exp_g;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
